// File: rtl/rom_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_reader
// Purpose  : Burst reader that walks a combinational ROM and hands each word
//            to a ready/valid consumer while keeping a running sum.
// Revision : 1.0
// ============================================================================
module rom_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic [DATA_W+4:0]   sum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [DATA_W+4:0]   sum_q, sum_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sum_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            sum_q       <= sum_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        valid_d     = valid_q;
        sum_d       = sum_q;
        case (state_q)
            IDLE: begin
                if (start && (length != '0)) begin
                    addr_d      = base_addr;
                    // Oversized requests are clamped to one full ROM sweep.
                    remaining_d = (length > MAX_LEN) ? MAX_LEN : length;
                    sum_d       = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                data_d  = rom_data;
                valid_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_d     = 1'b0;
                    sum_d       = sum_q + {5'b0, data_q};
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr  = addr_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule
`default_nettype wire
